counter_run_ctrl: RTL and testbench

COUNTER_RUN_CTRL -- requirements
Module: counter_run_ctrl

---
 rtl/counter_run_ctrl_pkg.sv | 22 ++
 rtl/counter_run_ctrl_btn_debounce.sv | 66 ++++++
 rtl/counter_run_ctrl.sv | 133 +++++++++++++
 tb/tb_counter_run_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_run_ctrl_pkg.sv
// counter_run_ctrl_pkg: shared counter-lab definitions (run-control state encoding, width helper).
// Rev 1.0
`timescale 1us/1ns
`default_nettype none

package counter_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HOLD  = 2'b11
  } run_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_run_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, consecutive-cycle level filter and one-cycle press pulse.
// Rev 1.0
`timescale 1us/1ns
`default_nettype none

module btn_debounce
  import counter_run_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int            CW     = cnt_width(DEB_CNT);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_lvl_d;
  logic          r_armed;
  logic          r_press;
  logic [1:0]    r_fill;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
      r_fill  <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_lvl_d <= r_lvl;
      // Presses are only honoured once the button has been seen released
      // after the synchronizer refilled; a button held through reset stays mute.
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end else if (!r_s2) begin
        r_armed <= 1'b1;
      end
      r_press <= r_lvl & ~r_lvl_d & r_armed;
    end
  end

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: start/pause/clear run controller with tick divider for an up-counter datapath.
// Rev 1.0
`timescale 1us/1ns
`default_nettype none

module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int DEB_CNT  = 8,
  parameter int TICK_DIV = 1000,
  parameter int WRAP     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_btn,
  input  logic       clr_btn,
  input  logic       cnt_at_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int            DW         = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(TICK_DIV - 1);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic          w_stop_press;
  logic          w_clr_press;
  run_state_e    r_state;
  run_state_e    w_nstate;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_ndiv;
  logic          w_nen;
  logic          w_nclr;
  logic          r_cnt_en;
  logic          r_cnt_clr;
  logic          r_running;

  // Asynchronous assertion, clock-synchronous release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_stop_deb (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (stop_btn),
    .o_press (w_stop_press)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_clr_deb (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_btn   (clr_btn),
    .o_press (w_clr_press)
  );

  always_comb begin
    w_nstate = r_state;
    w_ndiv   = r_div;
    w_nen    = 1'b0;
    w_nclr   = 1'b0;
    if (w_clr_press) begin
      w_nstate = ST_IDLE;
      w_ndiv   = '0;
      w_nclr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_ndiv = '0;
          if (w_stop_press) w_nstate = ST_RUN;
        end
        ST_RUN: begin
          if (w_stop_press) begin
            w_nstate = ST_PAUSE;
          end else if (r_div == C_DIV_LAST) begin
            w_ndiv = '0;
            if (WRAP != 0 || !cnt_at_max) w_nen = 1'b1;
            else                          w_nstate = ST_HOLD;
          end else begin
            w_ndiv = r_div + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (w_stop_press) w_nstate = ST_RUN;
        end
        ST_HOLD: begin
          w_ndiv = '0;
          if (w_stop_press) begin
            w_nstate = ST_IDLE;
            w_nclr   = 1'b1;
          end
        end
        default: begin
          w_nstate = ST_IDLE;
          w_ndiv   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_div     <= w_ndiv;
      r_cnt_en  <= w_nen;
      r_cnt_clr <= w_nclr;
      r_running <= (w_nstate == ST_RUN);
    end
  end

  assign cnt_en  = r_cnt_en;
  assign cnt_clr = r_cnt_clr;
  assign running = r_running;
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: randomized stimulus, event scoreboard against a behavioural reference model.
// Rev 1.0
`timescale 1us/1ns
`default_nettype none

module tb_counter_run_ctrl;

  localparam int DEB  = 8;
  localparam int TDIV = 10;
  localparam int WRP  = 0;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_HOLD = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stop_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       cnt_at_max = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mdl_on = 0;
  bit mon_on = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       en;
    logic       clr;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state: raw sample history per button, accepted levels, presses.
  bit         h_stop[$];
  bit         h_clr[$];
  bit         acc_s, acc_c, rose_s, rose_c, p_s, p_c;
  logic [1:0] m_st, m_prev;
  int         m_phase;

  counter_run_ctrl #(.DEB_CNT(DEB), .TICK_DIV(TDIV), .WRAP(WRP)) dut (
    .clk        (clk),
    .rst        (rst),
    .stop_btn   (stop_btn),
    .clr_btn    (clr_btn),
    .cnt_at_max (cnt_at_max),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Accepted level flips once the DEB most recent synchronized samples
  // (raw samples two edges old and beyond) all disagree with it.
  function automatic bit flips(input bit h[$], input bit acc);
    for (int j = 0; j < DEB; j++)
      if (h[h.size() - 3 - j] == acc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mdl_step();
    bit en, clr, f;
    en  = 0;
    clr = 0;
    h_stop.push_back(stop_btn);
    h_clr.push_back(clr_btn);
    if (p_c) begin
      m_st = S_IDLE; clr = 1; m_phase = 0;
    end else begin
      case (m_st)
        S_IDLE:  begin m_phase = 0; if (p_s) m_st = S_RUN; end
        S_PAUSE: if (p_s) m_st = S_RUN;
        S_HOLD:  begin m_phase = 0; if (p_s) begin m_st = S_IDLE; clr = 1; end end
        default: begin
          if (p_s) m_st = S_PAUSE;
          else begin
            m_phase++;
            if (m_phase == TDIV) begin
              m_phase = 0;
              if (WRP != 0 || !cnt_at_max) en = 1;
              else m_st = S_HOLD;
            end
          end
        end
      endcase
    end
    p_s = rose_s;
    p_c = rose_c;
    f = flips(h_stop, acc_s); rose_s = f && !acc_s; if (f) acc_s = !acc_s;
    f = flips(h_clr, acc_c);  rose_c = f && !acc_c; if (f) acc_c = !acc_c;
    while (h_stop.size() > 40) void'(h_stop.pop_front());
    while (h_clr.size() > 40) void'(h_clr.pop_front());
    if (m_st != m_prev || en || clr) exp_q.push_back('{cyc, m_st, en, clr});
    m_prev = m_st;
  endtask

  always @(posedge clk) if (mdl_on) mdl_step();

  logic [1:0] mon_prev = 2'b00;
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (mon_on) begin
      if (state !== mon_prev || cnt_en || cnt_clr) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: cyc=%0d st=%b en=%b clr=%b, none expected",
                   cyc - 1, state, cnt_en, cnt_clr);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc - 1 || e.st !== state || e.en !== cnt_en || e.clr !== cnt_clr ||
              running !== (e.st == S_RUN)) begin
            fails++;
            $display("FAIL event: got cyc=%0d st=%b en=%b clr=%b run=%b, expected cyc=%0d st=%b en=%b clr=%b run=%b",
                     cyc - 1, state, cnt_en, cnt_clr, running, e.cyc, e.st, e.en, e.clr, e.st == S_RUN);
          end
        end
      end
      mon_prev = state;
    end
  end

  // Called at a negedge with the DUT idle and both buttons long released.
  task automatic mdl_init();
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    h_stop.delete();
    h_clr.delete();
    for (int i = 0; i < DEB + 2; i++) begin h_stop.push_back(0); h_clr.push_back(0); end
    acc_s = 0; acc_c = 0; rose_s = 0; rose_c = 0; p_s = 0; p_c = 0;
    m_st = S_IDLE; m_prev = S_IDLE; m_phase = 0;
    mon_prev = S_IDLE;
    mdl_on = 1;
    mon_on = 1;
  endtask

  task automatic hold(input bit s, input bit c, input int n);
    stop_btn = s;
    clr_btn  = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic press_stop(); hold(1, 0, 12); hold(0, 0, 12); endtask
  task automatic press_clr();  hold(0, 1, 12); hold(0, 0, 12); endtask

  task automatic quiet_check(input string nm, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (state !== S_IDLE || cnt_en || cnt_clr || running) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", state, S_IDLE);
    chk("reset_cnt_en", cnt_en, 0);
    chk("reset_cnt_clr", cnt_clr, 0);
    chk("reset_running", running, 0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    mdl_init();

    // Bouncing start press, free run through several ticks.
    hold(1, 0, 1); hold(0, 0, 1); hold(1, 0, 2); hold(0, 0, 1); hold(1, 0, 2); hold(0, 0, 1);
    hold(1, 0, 10); hold(0, 0, 40);
    // Pause mid-phase and resume.
    hold(0, 0, 25); press_stop(); hold(0, 0, 15); press_stop(); hold(0, 0, 20);
    // Halt at max, then stop clears.
    cnt_at_max = 1'b1; hold(0, 0, 15); press_stop(); cnt_at_max = 1'b0;
    // Simultaneous stop and clear while paused.
    press_stop(); press_stop(); hold(1, 1, 12); hold(0, 0, 12);
    // Short clear glitch while running.
    press_stop(); hold(0, 1, 7); hold(0, 0, 20);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin hold(1, 0, $urandom_range(1, 14)); hold(0, 0, $urandom_range(1, 14)); end
        2:    begin hold(0, 1, $urandom_range(1, 14)); hold(0, 0, $urandom_range(1, 14)); end
        3:    begin hold(1, 1, $urandom_range(6, 12)); hold(0, 0, $urandom_range(1, 14)); end
        4:    hold(0, 0, $urandom_range(1, 30));
        default: begin cnt_at_max = 1'($urandom_range(0, 1)); hold(0, 0, 1); end
      endcase
    end

    // Reset mid-run with the divider part-way.
    cnt_at_max = 1'b0;
    hold(0, 0, 20); press_clr(); press_stop();
    begin
      int n = 0;
      while (!(m_st == S_RUN && m_phase == 7) && n < 200) begin @(negedge clk); n++; end
      chk("reach_div7_in_run", n < 200, 1);
    end
    mdl_on = 0; mon_on = 0;
    rst = 1'b0;
    #1;
    chk("async_rst_state", state, S_IDLE);
    chk("async_rst_outputs", {cnt_en, cnt_clr, running}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet_check("post_reset_quiet", 30);
    exp_q.delete();
    mdl_init();
    press_stop(); hold(0, 0, 25);

    // Button held through reset release produces no press until re-pressed.
    mdl_on = 0; mon_on = 0;
    exp_q.delete();
    stop_btn = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet_check("held_through_reset", 40);
    hold(0, 0, 15);
    mdl_init();
    press_stop(); hold(0, 0, 25);

    chk("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
